sequential_divider: RTL and testbench
=====================================

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 The block SHALL have one parameter: WORD_LENGTH, default 16, operand width in bits (minimum 2).
REQ-002 The block SHALL have one clock; reset SHALL be synchronous and active-high; ports named clk and reset as elsewhere in the codebase.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-006 Dividend  input  WORD_LENGTH  unsigned numerator; sampled only on the edge that accepts Start.
REQ-007 Divisor  input  WORD_LENGTH  unsigned denominator; sampled only on the edge that accepts Start.
REQ-008 ready  output  1  high while a valid result is held.
REQ-009 Quotient  output  WORD_LENGTH  registered unsigned quotient.
REQ-010 Remainder  output  WORD_LENGTH  registered unsigned remainder.
REQ-011 DivByZero  output  1  high with ready when the accepted Divisor was 0.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, BUSY and DONE.
REQ-013 IDLE, or DONE with Start=1 at edge E0, SHALL accept the request: capture Dividend and Divisor, clear ready and DivByZero, and enter BUSY. If Divisor=0, it SHALL enter DONE instead.
REQ-014 BUSY SHALL perform restoring division, one quotient bit per clock, MSB first, for exactly WORD_LENGTH iterations counted by an internal counter.
REQ-015 Each iteration SHALL shift {partial remainder, dividend} left by 1, then subtract Divisor from the partial remainder. If the result is non-negative, it SHALL keep the result and shift in quotient bit 1; otherwise it SHALL restore and shift in 0.
REQ-016 The partial remainder SHALL be WORD_LENGTH+1 bits wide so that no iteration overflows.
REQ-017 On the final iteration, Quotient and Remainder SHALL be loaded, ready SHALL be set, and the FSM SHALL enter DONE; ready SHALL be first high after edge E0+WORD_LENGTH.
REQ-018 Divide-by-zero SHALL give Quotient = all ones, Remainder = captured Dividend and DivByZero=1, with ready high after edge E0+1 and no iterations.
REQ-019 Results SHALL satisfy Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor, for every nonzero Divisor.
REQ-020 Start while in BUSY SHALL be ignored; the operation SHALL continue unchanged and the inputs SHALL not be re-sampled.
REQ-021 Quotient, Remainder and DivByZero SHALL hold their previous values throughout BUSY and update only on completion.
REQ-022 In DONE, ready SHALL stay high and the outputs SHALL stay stable until a Start is accepted.
REQ-023 When a Start is accepted in DONE, ready SHALL fall at that same edge, and back-to-back operations SHALL be allowed.
REQ-024 If Start is held high continuously, the block SHALL restart at every entry to DONE, with ready high for exactly one cycle per result.
REQ-025 Changes on Dividend or Divisor outside the accepting edge SHALL have no effect on the operation in progress.

Reset
REQ-026 When reset=1 at a rising edge, the FSM SHALL go to IDLE, and ready, DivByZero, Quotient, Remainder and the iteration counter SHALL be cleared to 0.
REQ-027 Reset SHALL take priority over Start.
REQ-028 Reset during BUSY SHALL abort the operation, with no partial result visible.
REQ-029 The first Start after reset is released SHALL be accepted normally.

Verification
REQ-030 WORD_LENGTH=16: Dividend=8, Divisor=3, Start pulsed 1 cycle -> after 16 edges ready=1, Quotient=2, Remainder=2, DivByZero=0.
REQ-031 Dividend=100, Divisor=7 -> Quotient=14, Remainder=2; then Start with Dividend=65535, Divisor=1 from DONE -> Quotient=65535, Remainder=0; ready low for the 16 edges in between.
REQ-032 Dividend=5, Divisor=0 -> after 1 edge ready=1, DivByZero=1, Quotient=16'hFFFF, Remainder=5; the next valid Start clears DivByZero.
REQ-033 Dividend=3, Divisor=9 -> Quotient=0, Remainder=3. A Start pulse plus changes to Dividend and Divisor mid-BUSY -> result unchanged, latency unchanged.
REQ-034 Reset asserted 5 edges into BUSY for 8/3 -> all outputs 0, FSM in IDLE; a fresh Start for 30/4 -> Quotient=7, Remainder=2 after 16 edges.
REQ-035 A random sweep of 1000 operand pairs (including 0 and max) SHALL be checked against REQ-019, with ready latency checked each time.

Source files
------------

// File: rtl/sequential_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, MSB first.
// Divide-by-zero finishes one edge after acceptance with an all-ones quotient.
module sequential_divider #(
  parameter int WORD_LENGTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Start,
  input  logic [WORD_LENGTH-1:0] Dividend,
  input  logic [WORD_LENGTH-1:0] Divisor,
  output logic                   ready,
  output logic [WORD_LENGTH-1:0] Quotient,
  output logic [WORD_LENGTH-1:0] Remainder,
  output logic                   DivByZero
);

  localparam int W     = WORD_LENGTH;
  localparam int CNT_W = $clog2(W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [W:0]       prem_q, prem_d;
  logic [W-1:0]     dvd_q, dvd_d;
  logic [W-1:0]     dsr_q, dsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     quo_q, quo_d;
  logic [W-1:0]     rem_q, rem_d;
  logic             ready_q, ready_d;
  logic             dbz_q, dbz_d;

  logic [W:0]       prem_sh;
  logic [W:0]       diff;
  logic             q_bit;
  logic [W:0]       prem_step;
  logic [W-1:0]     dvd_step;

  // Next-state and datapath: one restoring step per BUSY cycle.
  always_comb begin
    state_d = state_q;
    prem_d  = prem_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    ready_d = ready_q;
    dbz_d   = dbz_q;

    // Remainder stays below the divisor, so its top bit is always free for the shift.
    prem_sh   = {prem_q[W-1:0], dvd_q[W-1]};
    diff      = prem_sh - {1'b0, dsr_q};
    q_bit     = ~diff[W];
    prem_step = q_bit ? diff : prem_sh;
    dvd_step  = {dvd_q[W-2:0], q_bit};

    case (state_q)
      IDLE: begin
        if (Start) begin
          dvd_d   = Dividend;
          dsr_d   = Divisor;
          prem_d  = {(W+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = (Divisor == {W{1'b0}}) ? DONE : BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        prem_d = prem_step;
        dvd_d  = dvd_step;
        if (cnt_q == CNT_LAST) begin
          quo_d   = dvd_step;
          rem_d   = prem_step[W-1:0];
          ready_d = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        // DONE without ready means a divide-by-zero was just accepted.
        if (!ready_q) begin
          quo_d   = {W{1'b1}};
          rem_d   = dvd_q;
          dbz_d   = 1'b1;
          ready_d = 1'b1;
        end else if (Start) begin
          dvd_d   = Dividend;
          dsr_d   = Divisor;
          prem_d  = {(W+1){1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          ready_d = 1'b0;
          dbz_d   = 1'b0;
          state_d = (Divisor == {W{1'b0}}) ? DONE : BUSY;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prem_q  <= {(W+1){1'b0}};
      dvd_q   <= {W{1'b0}};
      dsr_q   <= {W{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      quo_q   <= {W{1'b0}};
      rem_q   <= {W{1'b0}};
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prem_q  <= prem_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      ready_q <= ready_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready     = ready_q;
  assign Quotient  = quo_q;
  assign Remainder = rem_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed and swept checks of sequential_divider at WORD_LENGTH=16.
module tb_sequential_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;

  int checks;
  int failures;

  sequential_divider #(.WORD_LENGTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .Start     (start),
    .Dividend  (dividend),
    .Divisor   (divisor),
    .ready     (ready),
    .Quotient  (quotient),
    .Remainder (remainder),
    .DivByZero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_ready(input int start_cnt, output int cycles);
    cycles = start_cnt;
    while (ready !== 1'b1 && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    tick();
    tick();
    start = 1'b1; dividend = 16'd8; divisor = 16'd0;
    tick();
    start = 1'b0; reset = 1'b0;
    tick();
    checks++;
    if (ready !== 1'b0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: ready=%b dbz=%b expected 0 0", ready, div_by_zero);
    end
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL reset_data: q=%0d r=%0d expected 0 0", quotient, remainder);
    end
  endtask

  task automatic test_basic();
    int lat;
    start_op(16'd8, 16'd3);
    wait_ready(0, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL basic_latency: got %0d expected 16", lat);
    end
    checks++;
    if (quotient !== 16'd2 || remainder !== 16'd2 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL basic_8_3: q=%0d r=%0d dbz=%b expected 2 2 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int low;
    start_op(16'd100, 16'd7);
    wait_ready(0, lat);
    checks++;
    if (lat !== 16 || quotient !== 16'd14 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL b2b_100_7: lat=%0d q=%0d r=%0d expected 16 14 2", lat, quotient, remainder);
    end
    start_op(16'd65535, 16'd1);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_ready_fall: ready=%b expected 0", ready);
    end
    low = 1;
    for (int i = 1; i < 16; i++) begin
      tick();
      if (ready === 1'b0) low++;
      if (i == 8) begin
        checks++;
        if (quotient !== 16'd14 || remainder !== 16'd2) begin
          failures++;
          $display("FAIL b2b_hold_busy: q=%0d r=%0d expected 14 2", quotient, remainder);
        end
      end
    end
    checks++;
    if (low !== 16) begin
      failures++;
      $display("FAIL b2b_ready_low: low cycles=%0d expected 16", low);
    end
    wait_ready(15, lat);
    checks++;
    if (lat !== 16 || quotient !== 16'd65535 || remainder !== 16'd0) begin
      failures++;
      $display("FAIL b2b_65535_1: lat=%0d q=%0d r=%0d expected 16 65535 0", lat, quotient, remainder);
    end
  endtask

  task automatic test_div_zero();
    int lat;
    start_op(16'd5, 16'd0);
    wait_ready(0, lat);
    checks++;
    if (lat !== 1 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_latency: lat=%0d dbz=%b expected 1 1", lat, div_by_zero);
    end
    checks++;
    if (quotient !== 16'hFFFF || remainder !== 16'd5) begin
      failures++;
      $display("FAIL dz_values: q=%h r=%0d expected ffff 5", quotient, remainder);
    end
    dividend = 16'd999; divisor = 16'd4;
    tick(); tick(); tick();
    checks++;
    if (ready !== 1'b1 || quotient !== 16'hFFFF || remainder !== 16'd5 || div_by_zero !== 1'b1) begin
      failures++;
      $display("FAIL dz_hold: ready=%b q=%h r=%0d dbz=%b expected 1 ffff 5 1", ready, quotient, remainder, div_by_zero);
    end
    start_op(16'd20, 16'd6);
    checks++;
    if (div_by_zero !== 1'b0 || ready !== 1'b0) begin
      failures++;
      $display("FAIL dz_clear: dbz=%b ready=%b expected 0 0", div_by_zero, ready);
    end
    wait_ready(0, lat);
    checks++;
    if (lat !== 16 || quotient !== 16'd3 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL dz_next_20_6: lat=%0d q=%0d r=%0d expected 16 3 2", lat, quotient, remainder);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    start_op(16'd3, 16'd9);
    tick(); tick(); tick();
    start = 1'b1; dividend = 16'd1000; divisor = 16'd2;
    tick();
    start = 1'b0; dividend = 16'd77; divisor = 16'd0;
    wait_ready(4, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL ignore_latency: got %0d expected 16", lat);
    end
    checks++;
    if (quotient !== 16'd0 || remainder !== 16'd3 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL ignore_3_9: q=%0d r=%0d dbz=%b expected 0 3 0", quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_reset_busy();
    int lat;
    int early;
    start_op(16'd8, 16'd3);
    tick(); tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (ready !== 1'b0 || quotient !== 16'd0 || remainder !== 16'd0 || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL rstbusy_clear: ready=%b q=%0d r=%0d dbz=%b expected all 0", ready, quotient, remainder, div_by_zero);
    end
    early = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready !== 1'b0 || quotient !== 16'd0) early++;
    end
    checks++;
    if (early !== 0) begin
      failures++;
      $display("FAIL rstbusy_abort: %0d cycles with result visible, expected 0", early);
    end
    start_op(16'd30, 16'd4);
    wait_ready(0, lat);
    checks++;
    if (lat !== 16 || quotient !== 16'd7 || remainder !== 16'd2) begin
      failures++;
      $display("FAIL rstbusy_30_4: lat=%0d q=%0d r=%0d expected 16 7 2", lat, quotient, remainder);
    end
  endtask

  task automatic test_continuous_start();
    int pulses;
    int doubles;
    int misplaced;
    int lat;
    logic prev;
    start = 1'b1; dividend = 16'd10; divisor = 16'd3;
    tick();
    pulses = 0; doubles = 0; misplaced = 0; prev = 1'b0;
    for (int i = 1; i <= 51; i++) begin
      tick();
      if (ready === 1'b1) begin
        pulses++;
        if (prev === 1'b1) doubles++;
        if ((i % 17) != 16) misplaced++;
        checks++;
        if (quotient !== 16'd3 || remainder !== 16'd1) begin
          failures++;
          $display("FAIL cont_value: q=%0d r=%0d expected 3 1", quotient, remainder);
        end
      end
      prev = ready;
    end
    start = 1'b0;
    checks++;
    if (pulses !== 3 || doubles !== 0 || misplaced !== 0) begin
      failures++;
      $display("FAIL cont_pulses: pulses=%0d doubles=%0d misplaced=%0d expected 3 0 0", pulses, doubles, misplaced);
    end
    wait_ready(0, lat);
    checks++;
    if (lat !== 16) begin
      failures++;
      $display("FAIL cont_drain: latency=%0d expected 16", lat);
    end
  endtask

  task automatic test_sweep();
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_q;
    logic [15:0] exp_r;
    int exp_lat;
    int lat;
    int unsigned recon;
    logic [15:0] dir_a [6] = '{16'd0, 16'd0, 16'd65535, 16'd65535, 16'd1, 16'd65535};
    logic [15:0] dir_b [6] = '{16'd0, 16'd5, 16'd65535, 16'd0, 16'd65535, 16'd2};
    for (int i = 0; i < 1000; i++) begin
      if (i < 6) begin
        a = dir_a[i];
        b = dir_b[i];
      end else begin
        a = 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      end
      if (b == 16'd0) begin
        exp_q = 16'hFFFF; exp_r = a; exp_lat = 1;
      end else begin
        exp_q = a / b; exp_r = a % b; exp_lat = 16;
      end
      start_op(a, b);
      wait_ready(0, lat);
      checks++;
      if (lat !== exp_lat || quotient !== exp_q || remainder !== exp_r || div_by_zero !== (b == 16'd0)) begin
        failures++;
        $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d dbz=%b expected %0d %0d %0d %b",
                 a, b, lat, quotient, remainder, div_by_zero, exp_lat, exp_q, exp_r, (b == 16'd0));
      end
      if (b != 16'd0) begin
        recon = 32'(quotient) * 32'(b) + 32'(remainder);
        checks++;
        if (recon !== 32'(a) || remainder >= b) begin
          failures++;
          $display("FAIL sweep_identity %0d/%0d: q*d+r=%0d r=%0d expected %0d and r<d", a, b, recon, remainder, a);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1; start = 1'b0; dividend = 16'd0; divisor = 16'd0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_busy_ignore();
    test_reset_busy();
    test_continuous_start();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
